ipv4_ttl_checksum_update: RTL and testbench
===========================================

# ipv4_ttl_checksum_update

Router output-port-lookup stage that sits directly downstream of the IP header checksum accumulator on the 256-bit AXI-Stream datapath. The stage holds the first beat of each IPv4 packet until the second beat supplies the low 16 bits of the destination address. It then verifies the complete 20-byte header checksum, decrements the TTL and rewrites the checksum incrementally per RFC 1624. Packets with a bad checksum or an expiring TTL are dropped and counted; all other traffic passes through unchanged.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output TDATA width; only 256 is supported.
- C_S_AXIS_DATA_WIDTH, 256, input TDATA width; only 256 is supported.
- C_M_AXIS_TUSER_WIDTH, 128, output TUSER width.
- C_S_AXIS_TUSER_WIDTH, 128, input TUSER width.
- FIFO_DEPTH_BITS, 2, log2 depth of the input FIFO.
- AXI_ACLK  in  1  single clock.
- AXI_RESETN  in  1  reset, asynchronous, active-low.
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  input stream.
- S_AXIS_TREADY  out  1  high when the input FIFO is not nearly full.
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  output stream.
- M_AXIS_TREADY  in  1  downstream ready.
- pkt_fwd_count  out  32  count of IPv4 packets that had their TTL decremented and were forwarded.
- bad_csum_count  out  32  count of IPv4 packets dropped for a bad header checksum.
- ttl_expired_count  out  32  count of IPv4 packets dropped because TTL was 0 or 1.

## Operation
- Beat-1 field layout:
  - Ethertype is [159:144].
  - The IP header words are [143:128], [127:112], [111:96], [95:80], [79:64], [63:48], [47:32], [31:16] and [15:0].
  - TTL is [79:72]; the header checksum (HC) is [63:48].
- Beat-2 field layout: the low destination-address word is [255:240].
- Input FIFO: fall-through, depth 2^FIFO_DEPTH_BITS. Each entry holds {TLAST, TUSER, TSTRB, TDATA}. A write occurs on S_AXIS_TVALID & S_AXIS_TREADY.
- FSM states:
  - IDLE: waits for the FIFO head, which is a first beat.
    - If ethertype is 0x0800, [143:136] is 0x45 and TLAST=0: copy the beat into the hold register, pop it, and go to WAIT_W2.
    - Otherwise: go to PASS and forward the packet untouched.
  - WAIT_W2: when the FIFO is non-empty, sum the 10 header words in a 20-bit adder. Fold the end-around carry twice and register the 16-bit result. Do not pop. Go to CALC.
  - CALC: classify the packet.
    - If the folded sum is not 0xFFFF: go to DROP and increment bad_csum_count.
    - Else if TTL is 0 or 1: go to DROP and increment ttl_expired_count.
    - Else: set TTL to TTL-1, set HC' = ~(~HC + ~m + m') with ones-complement 16-bit arithmetic (m = old [79:64], m' = new [79:64]), go to SEND_HDR and increment pkt_fwd_count.
  - SEND_HDR: present the modified hold register with its original TUSER and TSTRB, and TLAST=0. Go to PASS on M_AXIS_TREADY.
  - PASS: the FIFO head drives M_AXIS. Pop on M_AXIS_TREADY. On a popped TLAST, go to IDLE.
  - DROP: pop one FIFO beat per cycle with M_AXIS_TVALID=0. On a popped TLAST, go to IDLE.
- Counters wrap modulo 2^32 and increment exactly once per packet.
- Headers with IHL other than 5, non-IPv4 frames and single-beat frames pass through unmodified and are not counted.

## Timing
- Reset values:
  - FSM is IDLE and the FIFO is empty.
  - M_AXIS_TVALID=0 and all counters are 0.
  - S_AXIS_TREADY is 1 once reset is released.
- Pass-through latency: 0 cycles from the FIFO head (fall-through). Input-to-output latency is 1 cycle through the FIFO write.
- IPv4 header beat:
  - M_AXIS_TVALID rises 2 cycles after beat 2 first appears at the FIFO head (WAIT_W2, then CALC, then SEND_HDR).
  - Beat 2 follows on the cycle after the header is accepted.
- M_AXIS outputs hold stable while TVALID=1 and TREADY=0. No bubbles are inserted within PASS.
- A 2-beat packet whose beat 2 has TLAST set: SEND_HDR, then one PASS beat, then IDLE.
- A DROP decision is made in CALC; the held beat 1 is never emitted.
- Reset mid-packet clears the FSM and FIFO immediately (asynchronous). The next accepted beat is treated as a first beat.

## Test plan
- Valid header, 3-beat packet: 45 00 0054 0000 4000 40 01 26A7 0a000001 0a000002 (TTL 0x40) -> output [79:64]=0x3F01, [63:48]=0x27A7; all other bits and TUSER unchanged; pkt_fwd_count=1; the header appears 2 cycles after beat 2 reaches the FIFO head.
- Same header with checksum 0x26A6 -> no output beats; bad_csum_count=1; FSM returns to IDLE after the TLAST beat.
- Valid checksum with TTL=0x01 (checksum recomputed accordingly) -> packet dropped; ttl_expired_count=1; pkt_fwd_count unchanged.
- ARP frame (ethertype 0x0806), 2 beats -> output identical to input; all counters remain 0.
- Back-to-back valid IPv4 packets with M_AXIS_TREADY toggled 1/0 every cycle -> data holds while stalled, no beats lost or duplicated, both TTLs decremented, pkt_fwd_count=2; S_AXIS_TREADY deasserts when the FIFO is nearly full.
- AXI_RESETN asserted during the PASS state of a packet -> M_AXIS_TVALID=0 and counters 0 asynchronously; a fresh valid packet sent after release is forwarded correctly.

Source files
------------

// File: rtl/ipv4_ttl_checksum_update.sv
// IPv4 output-port-lookup stage: holds header beat, verifies the full header checksum,
// decrements TTL with an incremental checksum rewrite, drops bad/expiring packets.
module ipv4_ttl_checksum_update #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic [31:0]                         pkt_fwd_count,
  output logic [31:0]                         bad_csum_count,
  output logic [31:0]                         ttl_expired_count
);
  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int EW    = 1 + UW + SW + DW;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] NF_LVL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_W2, S_CALC, S_SEND_HDR, S_PASS, S_DROP} state_e;

  // ---------------- fall-through input FIFO ----------------
  logic [EW-1:0]              mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                       push, pop, empty;
  logic [EW-1:0]              head;
  logic [DW-1:0]              h_data;
  logic [SW-1:0]              h_strb;
  logic [UW-1:0]              h_user;
  logic                       h_last;

  assign S_AXIS_TREADY = (cnt_q < NF_LVL);
  assign push  = S_AXIS_TVALID & S_AXIS_TREADY;
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign {h_last, h_user, h_strb, h_data} = head;

  always_ff @(posedge AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------- header processing ----------------
  state_e        state_q, state_d;
  logic [15:0]   sum_q, sum_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [SW-1:0] hold_strb_q, hold_strb_d;
  logic [UW-1:0] hold_user_q, hold_user_d;
  logic [31:0]   fwd_q, fwd_d, bad_q, bad_d, ttl_q, ttl_d;

  logic          is_ip;
  logic [19:0]   sum20;
  logic [16:0]   fold1;
  logic [15:0]   fold2;
  logic [15:0]   m_old, m_new, hc_new, a16, b16;
  logic [16:0]   a17, b17;

  assign is_ip = (h_data[159:144] == 16'h0800) && (h_data[143:136] == 8'h45) && !h_last;

  // Nine header words from the held beat plus the low dst-address word at the head.
  always_comb begin
    sum20 = 20'(h_data[255:240]);
    for (int i = 0; i < 9; i++) sum20 = sum20 + 20'(hold_data_q[16*i +: 16]);
    fold1 = {1'b0, sum20[15:0]} + {13'b0, sum20[19:16]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
  end

  // Incremental update: HC' = ~(~HC + ~m + m') in ones-complement arithmetic.
  always_comb begin
    m_old  = hold_data_q[79:64];
    m_new  = {hold_data_q[79:72] - 8'd1, hold_data_q[71:64]};
    a17    = {1'b0, ~hold_data_q[63:48]} + {1'b0, ~m_old};
    a16    = a17[15:0] + {15'b0, a17[16]};
    b17    = {1'b0, a16} + {1'b0, m_new};
    b16    = b17[15:0] + {15'b0, b17[16]};
    hc_new = ~b16;
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    hold_data_d = hold_data_q;
    hold_strb_d = hold_strb_q;
    hold_user_d = hold_user_q;
    fwd_d       = fwd_q;
    bad_d       = bad_q;
    ttl_d       = ttl_q;
    pop         = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = h_data;
    M_AXIS_TSTRB  = h_strb;
    M_AXIS_TUSER  = h_user;
    M_AXIS_TLAST  = h_last;
    case (state_q)
      S_IDLE: if (!empty) begin
        if (is_ip) begin
          hold_data_d = h_data;
          hold_strb_d = h_strb;
          hold_user_d = h_user;
          pop         = 1'b1;
          state_d     = S_WAIT_W2;
        end else begin
          state_d = S_PASS;
        end
      end
      S_WAIT_W2: if (!empty) begin
        sum_d   = fold2;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (sum_q != 16'hFFFF) begin
          bad_d   = bad_q + 32'd1;
          state_d = S_DROP;
        end else if (hold_data_q[79:72] <= 8'd1) begin
          ttl_d   = ttl_q + 32'd1;
          state_d = S_DROP;
        end else begin
          hold_data_d[79:64] = m_new;
          hold_data_d[63:48] = hc_new;
          fwd_d   = fwd_q + 32'd1;
          state_d = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = hold_data_q;
        M_AXIS_TSTRB  = hold_strb_q;
        M_AXIS_TUSER  = hold_user_q;
        M_AXIS_TLAST  = 1'b0;
        if (M_AXIS_TREADY) state_d = S_PASS;
      end
      S_PASS: begin
        M_AXIS_TVALID = !empty;
        if (!empty && M_AXIS_TREADY) begin
          pop = 1'b1;
          if (h_last) state_d = S_IDLE;
        end
      end
      S_DROP: if (!empty) begin
        pop = 1'b1;
        if (h_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      hold_data_q <= '0;
      hold_strb_q <= '0;
      hold_user_q <= '0;
      fwd_q       <= '0;
      bad_q       <= '0;
      ttl_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      hold_data_q <= hold_data_d;
      hold_strb_q <= hold_strb_d;
      hold_user_q <= hold_user_d;
      fwd_q       <= fwd_d;
      bad_q       <= bad_d;
      ttl_q       <= ttl_d;
    end
  end

  assign pkt_fwd_count     = fwd_q;
  assign bad_csum_count    = bad_q;
  assign ttl_expired_count = ttl_q;
endmodule

// File: tb/tb_ipv4_ttl_checksum_update.sv
// Directed, table-driven bench for ipv4_ttl_checksum_update: vectors with hand-computed
// TTL/checksum results, plus stall/backpressure and mid-packet reset sequences.
module tb_ipv4_ttl_checksum_update;
  localparam int DW = 256, SW = 32, UW = 128;
  localparam int K_FWD = 0, K_PASS = 1, K_DROP = 2;

  logic          AXI_ACLK = 1'b0;
  logic          AXI_RESETN = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic [SW-1:0] S_AXIS_TSTRB = '0;
  logic [UW-1:0] S_AXIS_TUSER = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TLAST = 1'b0;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic [UW-1:0] M_AXIS_TUSER;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b1;
  logic [31:0]   pkt_fwd_count, bad_csum_count, ttl_expired_count;

  ipv4_ttl_checksum_update dut (
    .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .pkt_fwd_count(pkt_fwd_count), .bad_csum_count(bad_csum_count),
    .ttl_expired_count(ttl_expired_count)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [15:0] etype;
    logic [7:0]  verihl;
    logic [15:0] ttlp;     // {TTL, protocol}
    logic [15:0] hc;
    int          nbeats;
    int          kind;
    int          dbad;     // expected bad_csum_count increment
    int          dttl;     // expected ttl_expired_count increment
    logic [15:0] exp_ttlp;
    logic [15:0] exp_hc;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[9];
  int    ntests = 0, nfail = 0;
  int    cyc = 0;
  int    tmode = 1;          // M_AXIS_TREADY: 0 stall, 1 ready, 2 toggle
  bit    arm = 1'b0;
  int    first_vld_cyc = -100, b2_cyc = 0;
  bit    saw_nf = 1'b0;
  int    ef = 0, eb = 0, et = 0;

  always @(posedge AXI_ACLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(string name, beat_t a, beat_t e);
    ntests++;
    if (a.data !== e.data || a.strb !== e.strb || a.user !== e.user || a.last !== e.last) begin
      nfail++;
      $display("FAIL %s: got data=%h last=%b strb=%h user=%h expected data=%h last=%b strb=%h user=%h",
               name, a.data, a.last, a.strb, a.user, e.data, e.last, e.strb, e.user);
    end
  endtask

  function automatic beat_t mk_beat(int id, int bi, vec_t v);
    beat_t b;
    logic [7:0] a, c;
    a = 8'(id);
    c = 8'(bi);
    if (bi == 0)
      b.data = {{6{a, c}}, v.etype, v.verihl, 8'h00, 16'h0054, 16'h0000, 16'h4000,
                v.ttlp, v.hc, 16'h0a00, 16'h0001, 16'h0a00};
    else
      b.data = {16'h0002, {15{a, c}}};
    b.user = {4{a, c, 16'hBEEF}};
    b.last = (bi == v.nbeats - 1);
    b.strb = b.last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return b;
  endfunction

  task automatic expect_pkt(int id, vec_t v);
    beat_t b;
    if (v.kind == K_DROP) return;
    for (int bi = 0; bi < v.nbeats; bi++) begin
      b = mk_beat(id, bi, v);
      if (bi == 0 && v.kind == K_FWD) b.data[79:48] = {v.exp_ttlp, v.exp_hc};
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(beat_t b);
    int n;
    S_AXIS_TDATA  = b.data;
    S_AXIS_TSTRB  = b.strb;
    S_AXIS_TUSER  = b.user;
    S_AXIS_TLAST  = b.last;
    S_AXIS_TVALID = 1'b1;
    n = 0;
    @(negedge AXI_ACLK);
    while (!S_AXIS_TREADY && n < 200) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (n >= 200) begin
      ntests++;
      nfail++;
      $display("FAIL s_tready_timeout: got stuck low expected high");
    end
    @(posedge AXI_ACLK);
    #1;
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_pkt(int id, vec_t v);
    for (int bi = 0; bi < v.nbeats; bi++) begin
      send_beat(mk_beat(id, bi, v));
      if (bi == 1) b2_cyc = cyc;
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge AXI_ACLK);
      n++;
    end
    repeat (8) @(posedge AXI_ACLK);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_counters(string name);
    chk({name, "_fwd"}, 64'(pkt_fwd_count), 64'(ef));
    chk({name, "_bad"}, 64'(bad_csum_count), 64'(eb));
    chk({name, "_ttl"}, 64'(ttl_expired_count), 64'(et));
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge AXI_ACLK);
      #1;
      case (tmode)
        0:       M_AXIS_TREADY = 1'b0;
        2:       M_AXIS_TREADY = ~M_AXIS_TREADY;
        default: M_AXIS_TREADY = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard on handshakes, stability while stalled.
  initial begin
    beat_t cur, prev, e;
    bit prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge AXI_ACLK);
      cur.data = M_AXIS_TDATA;
      cur.strb = M_AXIS_TSTRB;
      cur.user = M_AXIS_TUSER;
      cur.last = M_AXIS_TLAST;
      if (!AXI_RESETN) begin
        prev_stall = 1'b0;
      end else begin
        if (!S_AXIS_TREADY) saw_nf = 1'b1;
        if (prev_stall) begin
          chk("stall_valid_hold", 64'(M_AXIS_TVALID), 64'd1);
          chk_beat("stall_data_hold", cur, prev);
        end
        if (arm && M_AXIS_TVALID) begin
          first_vld_cyc = cyc;
          arm = 1'b0;
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_beat: got data=%h expected no beat", cur.data);
          end else begin
            e = exp_q.pop_front();
            chk_beat("out_beat", cur, e);
          end
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev = cur;
      end
    end
  end

  initial begin
    // etype, ver/ihl, ttlp, hc, beats, kind, dbad, dttl, exp ttlp, exp hc
    vecs[0] = '{16'h0800, 8'h45, 16'h4001, 16'h26A7, 3, K_FWD,  0, 0, 16'h3F01, 16'h27A7};
    vecs[1] = '{16'h0800, 8'h45, 16'h4001, 16'h26A6, 3, K_DROP, 1, 0, 16'h0000, 16'h0000};
    vecs[2] = '{16'h0800, 8'h45, 16'h0101, 16'h65A7, 3, K_DROP, 0, 1, 16'h0000, 16'h0000};
    vecs[3] = '{16'h0800, 8'h45, 16'h0001, 16'h66A7, 2, K_DROP, 0, 1, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0800, 8'h45, 16'h0201, 16'h64A7, 2, K_FWD,  0, 0, 16'h0101, 16'h65A7};
    vecs[5] = '{16'h0800, 8'h45, 16'hFF01, 16'h67A6, 3, K_FWD,  0, 0, 16'hFE01, 16'h68A6};
    vecs[6] = '{16'h0806, 8'h45, 16'h4001, 16'h26A7, 2, K_PASS, 0, 0, 16'h0000, 16'h0000};
    vecs[7] = '{16'h0800, 8'h46, 16'h4001, 16'h26A7, 2, K_PASS, 0, 0, 16'h0000, 16'h0000};
    vecs[8] = '{16'h0800, 8'h45, 16'h4001, 16'h26A7, 1, K_PASS, 0, 0, 16'h0000, 16'h0000};

    // Reset state.
    #12;
    chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk_counters("rst");
    @(posedge AXI_ACLK);
    #1;
    AXI_RESETN = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'd1);

    // Table-driven vectors with downstream always ready.
    for (int i = 0; i < 9; i++) begin
      expect_pkt(i + 1, vecs[i]);
      first_vld_cyc = -100;
      arm = 1'b1;
      send_pkt(i + 1, vecs[i]);
      drain($sformatf("vec%0d_drain", i));
      arm = 1'b0;
      if (vecs[i].kind == K_FWD) begin
        ef++;
        chk($sformatf("vec%0d_hdr_latency", i), 64'(first_vld_cyc - b2_cyc), 64'd2);
      end
      eb += vecs[i].dbad;
      et += vecs[i].dttl;
      chk_counters($sformatf("vec%0d", i));
    end

    // Back-to-back packets with TREADY toggling each cycle.
    saw_nf = 1'b0;
    tmode = 2;
    expect_pkt(20, vecs[0]);
    expect_pkt(21, vecs[5]);
    send_pkt(20, vecs[0]);
    send_pkt(21, vecs[5]);
    drain("toggle_drain");
    ef += 2;
    chk_counters("toggle");
    chk("toggle_s_tready_low_seen", 64'(saw_nf), 64'd1);
    tmode = 1;
    repeat (3) @(posedge AXI_ACLK);
    #1;

    // Reset while a pass-through packet is stalled in PASS.
    tmode = 0;
    @(posedge AXI_ACLK);
    #1;
    begin
      vec_t arp3;
      arp3 = vecs[6];
      arp3.nbeats = 3;
      send_pkt(30, arp3);
    end
    repeat (3) @(posedge AXI_ACLK);
    #1;
    chk("pass_stalled_valid", 64'(M_AXIS_TVALID), 64'd1);
    #3;
    AXI_RESETN = 1'b0;
    #1;
    ef = 0; eb = 0; et = 0;
    chk("async_rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk_counters("async_rst");
    @(posedge AXI_ACLK);
    #1;
    AXI_RESETN = 1'b1;
    exp_q.delete();
    tmode = 1;
    @(posedge AXI_ACLK);
    #1;
    expect_pkt(31, vecs[0]);
    send_pkt(31, vecs[0]);
    drain("post_rst_drain");
    ef = 1;
    chk_counters("post_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
